// File: rtl/bram_sp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_sp_arbiter
// Brief    : Round-robin arbiter/sequencer for two requesters sharing one
//            single-port no-change BRAM. Tags read responses with the issuing
//            requester and provides a bulk-clear sequencer (zero fill).
// Options  : define BRAM_ARB_STATS_EN to add 32-bit per-requester grant
//            counters (grant_cnt0 / grant_cnt1).
// Revision : 1.0 - initial release
// ============================================================================
module bram_sp_arbiter #(
   parameter int RAM_WIDTH = 16,
   parameter int RAM_DEPTH = 1024,
   parameter int RD_LAT    = 2
) (
   input  logic                           clka,
   input  logic                           rsta,
   input  logic [1:0]                     req_valid,
   output logic [1:0]                     req_ready,
   input  logic [1:0]                     req_we,
   input  logic [2*$clog2(RAM_DEPTH)-1:0] req_addr,
   input  logic [2*RAM_WIDTH-1:0]         req_wdata,
   output logic [1:0]                     resp_valid,
   output logic [RAM_WIDTH-1:0]           resp_rdata,
   input  logic                           clr_start,
   output logic                           clr_busy,
   output logic                           clr_done,
   output logic [$clog2(RAM_DEPTH)-1:0]   bram_addra,
   output logic [RAM_WIDTH-1:0]           bram_dina,
   output logic                           bram_wea,
   output logic                           bram_ena,
   output logic                           bram_regcea,
   input  logic [RAM_WIDTH-1:0]           bram_douta
`ifdef BRAM_ARB_STATS_EN
   ,
   output logic [31:0]                    grant_cnt0,
   output logic [31:0]                    grant_cnt1
`endif
);

   localparam int              c_AW        = $clog2(RAM_DEPTH);
   localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(RAM_DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   r_rr_ptr;      // requester that wins the next tie
   logic [c_AW-1:0]        r_clr_addr;
   logic [RD_LAT:0]        r_pipe_vld;    // [0] = BRAM enable cycle, [RD_LAT] = response
   logic [RD_LAT:0]        r_pipe_id;

   logic [1:0]             w_grant;
   logic                   w_gnt_id;
   logic                   w_gnt_we;
   logic [c_AW-1:0]        w_gnt_addr;
   logic [RAM_WIDTH-1:0]   w_gnt_wdata;
   logic                   w_clr_go;
   logic                   w_pipe_empty;

   // Granted requester's payload
   assign w_gnt_we    = w_gnt_id ? req_we[1] : req_we[0];
   assign w_gnt_addr  = w_gnt_id ? req_addr[c_AW +: c_AW] : req_addr[0 +: c_AW];
   assign w_gnt_wdata = w_gnt_id ? req_wdata[RAM_WIDTH +: RAM_WIDTH]
                                 : req_wdata[0 +: RAM_WIDTH];

   assign w_pipe_empty = ~|r_pipe_vld;
   assign req_ready    = w_grant;
   assign clr_busy     = (r_state != S_IDLE);

   // Next-state, arbitration and clear-done decode
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 2'b00;
      w_gnt_id    = 1'b0;
      w_clr_go    = 1'b0;
      clr_done    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (clr_start) begin
               // Clear wins over any request in the same cycle
               w_clr_go    = 1'b1;
               w_state_nxt = S_CLEAR;
            end else if (req_valid == 2'b11) begin
               w_gnt_id = r_rr_ptr;
               w_grant  = r_rr_ptr ? 2'b10 : 2'b01;
            end else if (req_valid[1]) begin
               w_gnt_id = 1'b1;
               w_grant  = 2'b10;
            end else if (req_valid[0]) begin
               w_gnt_id = 1'b0;
               w_grant  = 2'b01;
            end
         end
         S_CLEAR: begin
            if (r_clr_addr == c_LAST_ADDR) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_pipe_empty) begin
               clr_done    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Round-robin pointer: always hand priority to the other requester after a grant
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta)          r_rr_ptr <= 1'b0;
      else if (|w_grant) r_rr_ptr <= ~w_gnt_id;
   end

   // Clear address counter, saturating at the last entry (non-power-of-two safe)
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta)                                                r_clr_addr <= '0;
      else if (w_clr_go)                                       r_clr_addr <= '0;
      else if (r_state == S_CLEAR && r_clr_addr != c_LAST_ADDR) r_clr_addr <= r_clr_addr + 1'b1;
   end

   // Registered BRAM port drive; address/data hold when idle
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         bram_ena   <= 1'b0;
         bram_wea   <= 1'b0;
         bram_addra <= '0;
         bram_dina  <= '0;
      end else if (r_state == S_CLEAR) begin
         bram_ena   <= 1'b1;
         bram_wea   <= 1'b1;
         bram_addra <= r_clr_addr;
         bram_dina  <= '0;
      end else if (|w_grant) begin
         bram_ena   <= 1'b1;
         bram_wea   <= w_gnt_we;
         bram_addra <= w_gnt_addr;
         bram_dina  <= w_gnt_wdata;
      end else begin
         bram_ena   <= 1'b0;
         bram_wea   <= 1'b0;
      end
   end

   // Read tracking shift register: valid bit and requester ID per stage
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         r_pipe_vld <= '0;
         r_pipe_id  <= '0;
      end else begin
         r_pipe_vld <= {r_pipe_vld[RD_LAT-1:0], (|w_grant) & ~w_gnt_we};
         r_pipe_id  <= {r_pipe_id[RD_LAT-1:0], w_gnt_id};
      end
   end

   // Output register enable only exists for the two-cycle BRAM configuration
   generate
      if (RD_LAT == 2) begin : g_regce_hp
         assign bram_regcea = r_pipe_vld[1];
      end else begin : g_regce_ll
         assign bram_regcea = 1'b0;
      end
   endgenerate

   assign resp_valid = {r_pipe_vld[RD_LAT] &  r_pipe_id[RD_LAT],
                        r_pipe_vld[RD_LAT] & ~r_pipe_id[RD_LAT]};
   assign resp_rdata = r_pipe_vld[RD_LAT] ? bram_douta : '0;

`ifdef BRAM_ARB_STATS_EN
   // Per-requester handshake counters, cleared when a bulk clear starts
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (w_clr_go) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (w_grant[0]) grant_cnt0 <= grant_cnt0 + 32'd1;
         if (w_grant[1]) grant_cnt1 <= grant_cnt1 + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/bram_sp_arbiter.md
Name: bram_sp_arbiter

Overview:
Two-requester arbiter and sequencer for one single-port no-change BRAM configured with a 2-cycle (HIGH_PERFORMANCE) read latency. It grants one read or write per cycle using round-robin between requesters 0 and 1. It drives the BRAM enable, write-enable and output-register-enable, and returns read data tagged to the requester that issued the read. It also contains a bulk-clear sequencer that writes zero to every BRAM entry. It sits between the datapath clients and the BRAM macro.

Parameters:
RAM_WIDTH, 16, data width; must match the attached BRAM.
RAM_DEPTH, 1024, number of entries; address width AW = $clog2(RAM_DEPTH).
RD_LAT, 2, BRAM read latency in cycles; legal values are 1 (LOW_LATENCY) and 2 (HIGH_PERFORMANCE).

Ports:
clka  in  1  clock
rsta  in  1  asynchronous active-high reset
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester grant, one-hot or zero
req_we  in  2  per-requester write (1) / read (0)
req_addr  in  2*AW  per-requester address, requester i in bits [i*AW +: AW]
req_wdata  in  2*RAM_WIDTH  per-requester write data
resp_valid  out  2  per-requester read-data-valid pulse
resp_rdata  out  RAM_WIDTH  read data, shared by both requesters
clr_start  in  1  bulk-clear start pulse
clr_busy  out  1  high while clearing or draining
clr_done  out  1  one-cycle pulse when the clear completes
bram_addra  out  AW  BRAM address
bram_dina  out  RAM_WIDTH  BRAM write data
bram_wea  out  1  BRAM write enable
bram_ena  out  1  BRAM enable
bram_regcea  out  1  BRAM output-register enable
bram_douta  in  RAM_WIDTH  BRAM read data

Behaviour:
- Reset:
  - Every output is 0; the FSM enters IDLE; the round-robin pointer is 0 (requester 0 wins the first tie).
  - Reset is asserted asynchronously and may occur mid-clear or with reads in flight. All in-flight reads are discarded and no resp_valid is produced for them.
- FSM states: IDLE, CLEAR, DRAIN.
  - IDLE -> CLEAR on clr_start. clr_start takes priority over any request in the same cycle; no grant is issued in that cycle.
  - CLEAR -> DRAIN after the write to address RAM_DEPTH-1.
  - DRAIN -> IDLE once the read pipeline is empty. clr_done pulses for one cycle on this transition.
  - clr_start is ignored outside IDLE.
- Arbitration (IDLE only):
  - A grant is combinational from req_valid and the pointer. req_ready[i] = 1 marks a handshake in that cycle.
  - One grant per cycle. With both requesters valid, the pointer selects the winner; after any grant the pointer moves to the other requester.
  - With a single requester valid, that requester is granted every cycle (back-to-back, full throughput).
- BRAM drive (registered, one cycle after the grant):
  - bram_ena = 1; bram_wea = granted req_we; bram_addra and bram_dina are taken from the granted requester.
  - With no grant: bram_ena = 0, bram_wea = 0, and address/data hold their previous values.
- Read pipeline:
  - A valid bit plus requester ID travels through an RD_LAT-deep shift register, starting at the cycle the BRAM is enabled for the read.
  - RD_LAT = 2: bram_regcea is 1 in the cycle that stage 1 holds a valid read, otherwise 0.
  - resp_valid[id] pulses together with resp_rdata = bram_douta. Response latency is RD_LAT+1 cycles from the grant: grant at cycle t -> resp_valid at t+3 when RD_LAT = 2.
  - Responses cannot be back-pressured. Reads issued back-to-back return back-to-back in issue order.
- Writes produce no response.
- A read to an address written in an earlier cycle returns the new data.
- Only no-change mode is used: a write never produces resp_valid.
- CLEAR:
  - Address counter runs 0..RAM_DEPTH-1, one write per cycle, with bram_wea = 1 and bram_dina = 0.
  - req_ready = 0 throughout CLEAR and DRAIN.
  - Reads granted before clr_start still complete and respond normally during CLEAR/DRAIN.
  - clr_busy = 1 from the cycle after clr_start through the clr_done cycle.
- Counter wrap: the address counter must not wrap past RAM_DEPTH-1, including when RAM_DEPTH is not a power of two.

Optional Feature:
BRAM_ARB_STATS_EN
- Defined: adds outputs grant_cnt0 and grant_cnt1, 32 bits each. Each counts handshakes of its requester and wraps modulo 2^32. Both are cleared by rsta and by the start of CLEAR.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with no activity -> all outputs 0. Requester 0 writes 0xABCD to address 5, then reads address 5 -> resp_valid[0] exactly 3 cycles after the read grant, resp_rdata = 0xABCD.
- Both requesters hold valid reads, to addresses 1 and 2, for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with 0. Responses alternate with matching IDs and data.
- Requester 1 alone issues 8 back-to-back reads -> 8 grants in 8 cycles, followed by 8 consecutive resp_valid[1] pulses in address order.
- Fill addresses 0..15, pulse clr_start with a read in flight -> the in-flight read responds; req_ready stays 0; exactly RAM_DEPTH zero writes occur; clr_done pulses once; a later read of address 7 returns 0.
- Assert rsta two cycles after a read grant and during CLEAR at address 100 -> no resp_valid, clr_busy = 0, FSM in IDLE, the next tie grants requester 0.
- With BRAM_ARB_STATS_EN defined: 5 grants to requester 0 and 3 to requester 1 -> grant_cnt0 = 5, grant_cnt1 = 3. Both read 0 after clr_start.
